// File: rtl/mem_stage_sized_if.sv
// Bus between the EX/MEM register, the memory stage and the MEM/WB register.
// A request (MemReadM|MemWriteM) is held stable while StallM=1; it completes in the first cycle with StallM=0.
interface mem_stage_sized_if;
    logic        MemReadM;
    logic        MemWriteM;
    logic [1:0]  MemSizeM;
    logic        MemSignedM;
    logic        RegWriteM;
    logic        MemToRegM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [4:0]  WriteRegM;
    logic [31:0] RD;
    logic        StallM;
    logic        MisalignM;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic [4:0]  WriteRegW;
    logic [4:0]  WriteRegM_hazard;
    logic [31:0] ALUOutW;
    logic        dbg_state;
    logic [2:0]  dbg_cnt;

    modport master (
        output MemReadM, MemWriteM, MemSizeM, MemSignedM, RegWriteM, MemToRegM,
               ALUOutM, WriteDataM, WriteRegM,
        input  RD, StallM, MisalignM, RegWriteW, MemtoRegW, WriteRegW,
               WriteRegM_hazard, ALUOutW, dbg_state, dbg_cnt
    );

    modport slave (
        input  MemReadM, MemWriteM, MemSizeM, MemSignedM, RegWriteM, MemToRegM,
               ALUOutM, WriteDataM, WriteRegM,
        output RD, StallM, MisalignM, RegWriteW, MemtoRegW, WriteRegW,
               WriteRegM_hazard, ALUOutW, dbg_state, dbg_cnt
    );
endinterface

// File: rtl/mem_stage_sized.sv
// MIPS memory stage with sized big-endian loads/stores, range/alignment checks
// and a configurable multi-cycle latency that stalls the pipeline.
module mem_stage_sized #(
    parameter int          ADDR_BITS = 10,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000
) (
    input  logic            clk,
    input  logic            reset,
    mem_stage_sized_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [2:0] CNT_INIT = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    function automatic logic [31:0] f_extend(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   res = sgn ? {{24{b[7]}}, b} : {24'd0, b};
            2'b01:   res = sgn ? {{16{h[15]}}, h} : {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] data,
                                            input logic [1:0] size, input logic [1:0] off);
        logic [31:0] res;
        res = old;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    res[31:24] = data[7:0];
                    2'd1:    res[23:16] = data[7:0];
                    2'd2:    res[15:8]  = data[7:0];
                    default: res[7:0]   = data[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) res[15:0] = data[15:0];
                else        res[31:16] = data[15:0];
            end
            default: res = data;
        endcase
        return res;
    endfunction

    logic [31:0] r_mem [0:DEPTH-1];
    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_rdata_q;

    state_t         w_state_d;
    logic [2:0]     w_cnt_d;
    logic           w_stall;
    logic [31:0]    w_rd;
    logic           w_load;
    logic           w_commit;
    logic [31:0]    w_off;
    logic           w_in_range;
    logic [ADDR_BITS-1:0] w_idx;
    logic           w_req;
    logic           w_misalign;
    logic           w_access;
    logic [31:0]    w_word;
    logic [31:0]    w_ext_now;
    logic [31:0]    w_ext_q;
    logic [31:0]    w_wr_data;
    logic           w_we;

    // BASE_ADDR is word aligned, so the lane offset comes straight from the relative address.
    assign w_off      = bus.ALUOutM - BASE_ADDR;
    assign w_in_range = (bus.ALUOutM >= BASE_ADDR) && (w_off[31:ADDR_BITS+2] == '0);
    assign w_idx      = w_off[ADDR_BITS+1:2];
    assign w_req      = bus.MemReadM | bus.MemWriteM;
    assign w_misalign = w_req & ((bus.MemSizeM[1] & (bus.ALUOutM[1:0] != 2'b00)) |
                                 ((bus.MemSizeM == 2'b01) & bus.ALUOutM[0]));
    assign w_access   = w_req & ~w_misalign;
    assign w_word     = w_in_range ? r_mem[w_idx] : 32'd0;
    assign w_ext_now  = f_extend(w_word, bus.MemSizeM, w_off[1:0], bus.MemSignedM);
    assign w_ext_q    = f_extend(r_rdata_q, bus.MemSizeM, w_off[1:0], bus.MemSignedM);
    assign w_wr_data  = f_merge(w_word, bus.WriteDataM, bus.MemSizeM, w_off[1:0]);
    assign w_we       = w_commit & bus.MemWriteM & w_in_range;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_stall   = 1'b0;
        w_rd      = 32'd0;
        w_load    = 1'b0;
        w_commit  = 1'b0;
        if (LATENCY == 0) begin
            w_rd     = w_access ? w_ext_now : 32'd0;
            w_commit = w_access;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        w_stall   = 1'b1;
                        w_load    = 1'b1;
                        w_state_d = S_WAIT;
                        w_cnt_d   = CNT_INIT;
                    end
                end
                default: begin
                    if (r_cnt != 3'd0) begin
                        w_stall = 1'b1;
                        w_cnt_d = r_cnt - 3'd1;
                    end else begin
                        w_rd      = w_ext_q;
                        w_commit  = w_access;
                        w_state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 3'd0;
            r_rdata_q <= 32'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_load) r_rdata_q <= w_word;
        end
    end

    // Reset suppresses the commit so an abandoned store never lands.
    always_ff @(posedge clk) begin
        if (!reset && w_we) r_mem[w_idx] <= w_wr_data;
    end

    assign bus.RD               = w_rd;
    assign bus.StallM           = w_stall;
    assign bus.MisalignM        = w_misalign;
    assign bus.RegWriteW        = bus.RegWriteM & ~w_misalign;
    assign bus.MemtoRegW        = bus.MemToRegM;
    assign bus.WriteRegW        = bus.WriteRegM;
    assign bus.WriteRegM_hazard = bus.WriteRegM;
    assign bus.ALUOutW          = bus.ALUOutM;
    assign bus.dbg_state        = r_state;
    assign bus.dbg_cnt          = r_cnt;
endmodule

// File: tb/tb_mem_stage_sized.sv
// Directed bench for mem_stage_sized at LATENCY 0, 2 and 3 with a load-result scoreboard.
module tb_mem_stage_sized;
    localparam logic [31:0] B = 32'h1001_0000;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    mem_stage_sized_if if0 ();
    mem_stage_sized_if if2 ();
    mem_stage_sized_if if3 ();

    mem_stage_sized #(.LATENCY(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
    mem_stage_sized #(.LATENCY(2)) u2 (.clk(clk), .reset(reset), .bus(if2));
    mem_stage_sized #(.LATENCY(3)) u3 (.clk(clk), .reset(reset), .bus(if3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int dut, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] d);
        case (dut)
            0: begin
                if0.MemReadM = rd; if0.MemWriteM = wr; if0.MemSizeM = sz; if0.MemSignedM = sg;
                if0.RegWriteM = 1'b1; if0.MemToRegM = rd; if0.ALUOutM = a; if0.WriteDataM = d;
            end
            2: begin
                if2.MemReadM = rd; if2.MemWriteM = wr; if2.MemSizeM = sz; if2.MemSignedM = sg;
                if2.RegWriteM = 1'b1; if2.MemToRegM = rd; if2.ALUOutM = a; if2.WriteDataM = d;
            end
            default: begin
                if3.MemReadM = rd; if3.MemWriteM = wr; if3.MemSizeM = sz; if3.MemSignedM = sg;
                if3.RegWriteM = 1'b1; if3.MemToRegM = rd; if3.ALUOutM = a; if3.WriteDataM = d;
            end
        endcase
    endtask

    function automatic logic [31:0] get_rd(input int dut);
        return (dut == 0) ? if0.RD : (dut == 2) ? if2.RD : if3.RD;
    endfunction

    function automatic logic get_stall(input int dut);
        return (dut == 0) ? if0.StallM : (dut == 2) ? if2.StallM : if3.StallM;
    endfunction

    function automatic logic get_state(input int dut);
        return (dut == 0) ? if0.dbg_state : (dut == 2) ? if2.dbg_state : if3.dbg_state;
    endfunction

    // One complete access: drive, wait out the stall (bounded), score the load, return to idle.
    task automatic access(input int dut, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input int exp_stalls);
        int stalls;
        logic done;
        stalls = 0;
        done   = 1'b0;
        @(negedge clk);
        drv(dut, rd, wr, sz, sg, a, d);
        if (rd) exp_q.push_back(exp_rd);
        for (int c = 0; c < 12 && !done; c++) begin
            #1;
            if (get_stall(dut)) begin
                stalls++;
                check("rd_zero_in_stall", get_rd(dut), 32'd0);
                @(negedge clk);
            end else begin
                done = 1'b1;
                if (rd) check("load_rd", get_rd(dut), exp_q.pop_front());
            end
        end
        check("access_completed", {31'd0, done}, 32'd1);
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        @(negedge clk);
        drv(dut, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
        #1;
        check("back_to_idle", {31'd0, get_state(dut)}, 32'd0);
        check("idle_stall", {31'd0, get_stall(dut)}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        if0.WriteRegM = 5'd9; if2.WriteRegM = 5'd9; if3.WriteRegM = 5'd9;
        drv(0, 0, 0, 2'b10, 0, 0, 0);
        drv(2, 0, 0, 2'b10, 0, 0, 0);
        drv(3, 0, 0, 2'b10, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drv(2, 1, 0, 2'b10, 0, B + 32'd2, 0);
        #1;
        check("reset_rd", if2.RD, 32'd0);
        check("reset_stall", {31'd0, if2.StallM}, 32'd0);
        check("reset_state", {31'd0, if3.dbg_state}, 32'd0);
        check("reset_misalign_follows", {31'd0, if2.MisalignM}, 32'd1);
        @(negedge clk);
        drv(2, 0, 0, 2'b10, 0, 0, 0);
        reset = 1'b0;

        // LATENCY 0
        access(0, 0, 1, 2'b10, 0, B + 32'd4, 32'hDEADBEEF, 32'd0, 0);
        access(0, 1, 0, 2'b10, 0, B + 32'd4, 32'd0, 32'hDEADBEEF, 0);
        @(negedge clk);
        if0.WriteRegM = 5'd17;
        drv(0, 1, 0, 2'b10, 0, B + 32'd4, 0);
        #1;
        check("alu_passthru", if0.ALUOutW, B + 32'd4);
        check("wreg_passthru", {27'd0, if0.WriteRegW}, 32'd17);
        check("wreg_hazard", {27'd0, if0.WriteRegM_hazard}, 32'd17);
        check("memtoreg_passthru", {31'd0, if0.MemtoRegW}, 32'd1);
        check("regwrite_aligned", {31'd0, if0.RegWriteW}, 32'd1);
        access(0, 0, 1, 2'b10, 0, B, 32'h11223344, 32'd0, 0);
        access(0, 0, 1, 2'b00, 0, B + 32'd1, 32'h00000080, 32'd0, 0);
        access(0, 1, 0, 2'b00, 1, B + 32'd1, 32'd0, 32'hFFFFFF80, 0);
        access(0, 1, 0, 2'b00, 0, B + 32'd1, 32'd0, 32'h00000080, 0);
        access(0, 1, 0, 2'b10, 0, B, 32'd0, 32'h11803344, 0);
        access(0, 1, 0, 2'b00, 1, B + 32'd3, 32'd0, 32'h00000044, 0);
        access(0, 1, 0, 2'b01, 1, B, 32'd0, 32'h00001180, 0);
        access(0, 0, 1, 2'b01, 0, B + 32'd6, 32'h00008001, 32'd0, 0);
        access(0, 1, 0, 2'b01, 1, B + 32'd6, 32'd0, 32'hFFFF8001, 0);
        access(0, 1, 0, 2'b01, 0, B + 32'd6, 32'd0, 32'h00008001, 0);
        access(0, 1, 0, 2'b11, 1, B + 32'd4, 32'd0, 32'hDEAD8001, 0);
        access(0, 1, 0, 2'b10, 0, 32'h0000_0100, 32'd0, 32'd0, 0);
        access(0, 0, 1, 2'b10, 0, B + 32'h1000, 32'hCAFEF00D, 32'd0, 0);
        access(0, 0, 1, 2'b10, 0, B + 32'h1004, 32'hCAFEF00D, 32'd0, 0);
        access(0, 1, 0, 2'b10, 0, B, 32'd0, 32'h11803344, 0);
        access(0, 1, 0, 2'b10, 0, B + 32'd4, 32'd0, 32'hDEAD8001, 0);
        access(0, 1, 0, 2'b10, 0, B + 32'h1000, 32'd0, 32'd0, 0);

        // LATENCY 2
        access(2, 0, 1, 2'b10, 0, B, 32'h12345678, 32'd0, 2);
        access(2, 1, 0, 2'b10, 0, B, 32'd0, 32'h12345678, 2);
        @(negedge clk);
        drv(2, 1, 0, 2'b01, 1, B + 32'd3, 0);
        #1;
        check("lh_misalign", {31'd0, if2.MisalignM}, 32'd1);
        check("lh_misalign_regwrite", {31'd0, if2.RegWriteW}, 32'd0);
        check("lh_misalign_rd", if2.RD, 32'd0);
        check("lh_misalign_stall", {31'd0, if2.StallM}, 32'd0);
        @(negedge clk);
        drv(2, 0, 1, 2'b01, 0, B + 32'd1, 32'h0000FFFF);
        #1;
        check("sh_misalign", {31'd0, if2.MisalignM}, 32'd1);
        check("sh_misalign_stall", {31'd0, if2.StallM}, 32'd0);
        @(negedge clk);
        drv(2, 0, 0, 2'b10, 0, 0, 0);
        access(2, 1, 0, 2'b10, 0, B, 32'd0, 32'h12345678, 2);
        access(2, 0, 1, 2'b10, 0, B + 32'hC, 32'h0A0B0C0D, 32'd0, 2);
        access(2, 1, 1, 2'b00, 0, B + 32'hE, 32'h00000077, 32'h0000000C, 2);
        access(2, 1, 0, 2'b10, 0, B + 32'hC, 32'd0, 32'h0A0B770D, 2);

        // LATENCY 3 with reset during the second stall cycle of a store
        access(3, 0, 1, 2'b10, 0, B + 32'd8, 32'hAAAAAAAA, 32'd0, 3);
        @(negedge clk);
        drv(3, 0, 1, 2'b10, 0, B + 32'd8, 32'h55555555);
        #1;
        check("l3_stall_1", {31'd0, if3.StallM}, 32'd1);
        @(negedge clk);
        #1;
        check("l3_stall_2", {31'd0, if3.StallM}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drv(3, 0, 0, 2'b10, 0, 0, 0);
        #1;
        check("l3_after_reset_stall", {31'd0, if3.StallM}, 32'd0);
        check("l3_after_reset_state", {31'd0, if3.dbg_state}, 32'd0);
        access(3, 1, 0, 2'b10, 0, B + 32'd8, 32'd0, 32'hAAAAAAAA, 3);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_stage_sized.md
Name: mem_stage_sized

Overview:
Parametrised successor to the MIPS pipeline memory stage. It adds byte, halfword and word loads and stores with sign or zero extension, and a configurable multi-cycle data-memory latency with a stall output to the hazard unit. It also detects misaligned and out-of-range accesses. It sits between the EX/MEM and MEM/WB pipeline registers and owns the data-memory array.

Parameters:
ADDR_BITS, 10, word-address bits; array depth = 2**ADDR_BITS 32-bit words
LATENCY, 2, access latency in stall cycles (0..7); 0 = single-cycle combinational read
BASE_ADDR, 32'h1001_0000, byte address mapped to word 0

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
MemReadM  input  1  load in M stage
MemWriteM  input  1  store in M stage
MemSizeM  input  2  00 byte, 01 half, 10 word, 11 treated as word
MemSignedM  input  1  1 = sign-extend loads, 0 = zero-extend
RegWriteM  input  1  control passthrough
MemToRegM  input  1  control passthrough
ALUOutM  input  32  byte address / ALU result
WriteDataM  input  32  store data, right-justified
WriteRegM  input  5  destination register
RD  output  32  extended load data
StallM  output  1  freeze F/D/E/M pipeline registers
MisalignM  output  1  alignment fault this cycle
RegWriteW  output  1  RegWriteM gated by !MisalignM
MemtoRegW  output  1  = MemToRegM
WriteRegW  output  5  = WriteRegM
WriteRegM_hazard  output  5  = WriteRegM
ALUOutW  output  32  = ALUOutM

Behaviour:
- Passthroughs (MemtoRegW, WriteRegW, WriteRegM_hazard, ALUOutW) are combinational.
- RegWriteW = RegWriteM & !MisalignM.
- Byte order is big-endian. Byte offset 0 = bits 31:24. Half offset 0 = bits 31:16.
- Index = (ALUOutM - BASE_ADDR) >> 2. In range iff ALUOutM >= BASE_ADDR and index < 2**ADDR_BITS.
- Out-of-range access: reads return 0, writes are dropped. Stall timing is unchanged.
- MisalignM (combinational) = access & ((word & addr[1:0]!=0) | (half & addr[0])). A misaligned access causes no memory access, no stall and RD=0.
- Access = (MemReadM | MemWriteM) & !MisalignM.
- If read and write are asserted together, the write is performed and RD shows the pre-write word, extended.
- Store: read-modify-write of the selected lane(s) only. Other bytes are preserved.
- Load: select lane, then sign- or zero-extend to 32 bits per MemSignedM. Word loads are unchanged by extension.
- FSM states: IDLE, WAIT. A 3-bit counter cnt.
- LATENCY=0: no FSM activity and StallM is always 0. RD is combinational from the array. The write commits at the clock edge ending the access cycle.
- LATENCY>=1 timing:
  - IDLE with access: StallM=1 and RD=0. At the edge, the array word is sampled into rdata_q, cnt <= LATENCY-1, and state goes to WAIT.
  - WAIT with cnt!=0: StallM=1, RD=0, cnt decrements.
  - WAIT with cnt==0: StallM=0 and RD = extend(rdata_q). The write commits at this edge, and state returns to IDLE.
  - Total stall cycles = LATENCY. The access occupies LATENCY+1 cycles.
- Inputs are held stable by the pipeline while StallM=1. The block does not re-sample them.
- Reset (synchronous): state=IDLE, cnt=0, rdata_q=0. Outputs after reset: StallM=0, RD=0, MisalignM follows inputs.
- Reset mid-WAIT abandons the access. A pending write is not committed.
- Array contents are not cleared by reset. Simulation initial value is 0.
- No access in IDLE: RD=0, StallM=0.

Test Plan:
- LATENCY=0: SW 0xDEADBEEF @0x10010004, then LW @0x10010004 -> RD=0xDEADBEEF, StallM never 1.
- SB 0x80 @0x10010001 over word 0x11223344, then LB → RD=0xFFFFFF80. LBU → 0x00000080. LW → 0x11803344.
- LATENCY=2, LW at request cycle T → StallM=1 in T and T+1. In T+2, StallM=0 and RD is valid. In T+3 the FSM is back in IDLE.
- LH @0x10010003 → MisalignM=1, RegWriteW=0, RD=0, StallM=0, memory unchanged.
- LATENCY=3, SW issued, reset asserted in 2nd stall cycle → StallM=0 next cycle, target word retains old value.
- LW @0x0000_0100 (below BASE_ADDR) → RD=0. SW beyond depth → no array word changes.
